// File: rtl/counter_pkg.sv
// Shared helpers for the parametrised up/down counter: width math and the
// next-count source selector.
package counter_pkg;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_CLEAR = 2'd1,
        SEL_LOAD  = 2'd2,
        SEL_STEP  = 2'd3
    } cnt_sel_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned r;
        longint unsigned t;
        r = 0;
        t = 1;
        while (t < v) begin
            t = t << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Prescaler counter width for a given divide ratio; never narrower than 1 bit.
    function automatic int unsigned ps_width(input longint unsigned prescale);
        int unsigned w;
        w = clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int unsigned PRESCALE_DEFAULT = 1;
    localparam int unsigned PS_W = ps_width(PRESCALE_DEFAULT);

endpackage

// File: rtl/param_updown_counter_prescale_tick.sv
// Enable-gated prescaler: strobes tick_c on the enabled cycle that completes
// PRESCALE enabled cycles; restart returns the phase to zero.
module prescale_tick
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic restart,
    output logic tick_c
);

    localparam int unsigned PSW = ps_width(PRESCALE);
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

    logic [PSW-1:0] ps_q;
    logic [PSW-1:0] ps_d;

    assign tick_c = en && (ps_q == PS_LAST);

    always_comb begin
        ps_d = ps_q;
        if (restart) begin
            ps_d = '0;
        end else if (tick_c) begin
            ps_d = '0;
        end else if (en) begin
            ps_d = ps_q + PSW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down modulo counter with prescaler, clear/load, wrap or saturate,
// terminal-count pulse and sticky boundary flag.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic             wrap_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
);

    localparam int unsigned    EW      = WIDTH + 1;
    localparam logic [EW-1:0]  MOD_EXT = EW'(MODULUS);
    localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MODULUS - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "param_updown_counter: WIDTH must be in 2..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "param_updown_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
        $fatal(1, "param_updown_counter: PRESCALE must be in 1..65536");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             wrapped_q, wrapped_d;

    logic             tick_c;
    logic             restart_c;
    cnt_sel_e         sel_c;
    logic [EW-1:0]    cnt_ext_c;
    logic [EW-1:0]    stepped_c;
    logic             at_bound_c;
    logic             boundary_c;
    logic [WIDTH-1:0] load_clamped_c;

    assign restart_c = clear | load;

    prescale_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .restart (restart_c),
        .tick_c  (tick_c)
    );

    // Priority: clear > load > step.
    always_comb begin
        sel_c = SEL_HOLD;
        if (clear) begin
            sel_c = SEL_CLEAR;
        end else if (load) begin
            sel_c = SEL_LOAD;
        end else if (tick_c) begin
            sel_c = SEL_STEP;
        end
    end

    // Candidate count in WIDTH+1 bits: overflow shows as == MODULUS, underflow as the top bit.
    always_comb begin
        cnt_ext_c      = {1'b0, count_q};
        stepped_c      = up ? (cnt_ext_c + EW'(1)) : (cnt_ext_c - EW'(1));
        at_bound_c     = up ? (stepped_c == MOD_EXT) : stepped_c[EW-1];
        load_clamped_c = ({1'b0, load_val} >= MOD_EXT) ? MOD_M1 : load_val;
    end

    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        wrapped_d  = wrapped_q;
        boundary_c = 1'b0;
        case (sel_c)
            SEL_CLEAR: begin
                count_d   = '0;
                wrapped_d = 1'b0;
            end
            SEL_LOAD: begin
                count_d = load_clamped_c;
            end
            SEL_STEP: begin
                if (at_bound_c) begin
                    boundary_c = 1'b1;
                    if (sat_mode) begin
                        count_d = count_q;
                    end else begin
                        count_d = up ? '0 : MOD_M1;
                    end
                end else begin
                    count_d = stepped_c[WIDTH-1:0];
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase

        tc_d = boundary_c;
        // A boundary event in the same cycle as wrap_clr keeps the flag set.
        if (sel_c != SEL_CLEAR) begin
            if (boundary_c) begin
                wrapped_d = 1'b1;
            end else if (wrap_clr) begin
                wrapped_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            tc_q      <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            tc_q      <= tc_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign wrapped = wrapped_q;

endmodule
